// File: rtl/arith_pkg.sv
// Shared definitions for the serial subtractor: FSM encoding and sizing helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of DIGIT-wide chunks needed to cover SIZE bits.
  function automatic int nchunk(input int size, input int digit);
    return size / digit;
  endfunction

  // One spare bit so the counter can never alias on the last chunk.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor.
// Latency: n/a (wires only).
// Backpressure: none; start is ignored while busy, consumers qualify results on done.
interface serial_subtractor_if #(
  parameter int SIZE = 8
);
  logic            start;
  logic [SIZE-1:0] A;
  logic [SIZE-1:0] B;
  logic            bin;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] Diff;
  logic            bout;
  logic            overflow;
  logic            zero;

  modport master (
    output start, A, B, bin,
    input  busy, done, Diff, bout, overflow, zero
  );

  modport slave (
    input  start, A, B, bin,
    output busy, done, Diff, bout, overflow, zero
  );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Latency: combinational.
// Backpressure: none.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/sub_slice.sv
// DIGIT-wide subtract chunk: a + ~b + cin through a ripple of full_adder cells.
// Latency: combinational.
// Backpressure: none.
module sub_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);
  logic [DIGIT:0] c;

  assign c[0] = cin;
  assign cout = c[DIGIT];

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end
endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle A - B - bin, DIGIT bits per clock through one reused sub_slice.
// Latency: busy for SIZE/DIGIT cycles after the capture edge, then a one-cycle done.
// Backpressure: start is only accepted in IDLE or DONE; start while busy is dropped.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int DIGIT = 1
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave io
);
  localparam int NCHUNK = nchunk(SIZE, DIGIT);
  localparam int CNT_W  = cnt_width(NCHUNK);

  if (SIZE % DIGIT != 0) begin : g_bad_digit
    $error("serial_subtractor: DIGIT must divide SIZE exactly");
  end

  state_t            state, state_nxt;
  logic [SIZE-1:0]   a_sh, b_sh;
  logic [SIZE-1:0]   diff_acc, diff_nxt;
  logic              a_msb, b_msb;
  logic              carry;
  logic [CNT_W-1:0]  cnt;
  logic [DIGIT-1:0]  chunk_sum;
  logic              chunk_cout;
  logic              accept;
  logic              last_chunk;

  assign accept     = io.start && (state != ST_RUN);
  assign last_chunk = (cnt == CNT_W'(NCHUNK - 1));
  assign io.busy    = (state == ST_RUN);
  assign io.done    = (state == ST_DONE);

  // Operands shift right so the active chunk always sits in the low DIGIT bits.
  sub_slice #(.DIGIT(DIGIT)) u_slice (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .cin  (carry),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // New chunk enters at the top; after NCHUNK shifts chunk 0 lands at bit 0.
  assign diff_nxt = (diff_acc >> DIGIT) | (SIZE'(chunk_sum) << (SIZE - DIGIT));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: DONE accepts a new start exactly like IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (io.start) state_nxt = ST_RUN;
      ST_RUN:  if (last_chunk) state_nxt = ST_DONE;
      ST_DONE: state_nxt = io.start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture, per-chunk accumulate, and result/flag update on the last chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh        <= '0;
      b_sh        <= '0;
      a_msb       <= 1'b0;
      b_msb       <= 1'b0;
      carry       <= 1'b0;
      cnt         <= '0;
      diff_acc    <= '0;
      io.Diff     <= '0;
      io.bout     <= 1'b0;
      io.overflow <= 1'b0;
      io.zero     <= 1'b0;
    end else if (accept) begin
      a_sh     <= io.A;
      b_sh     <= io.B;
      a_msb    <= io.A[SIZE-1];
      b_msb    <= io.B[SIZE-1];
      carry    <= ~io.bin;
      cnt      <= '0;
      diff_acc <= '0;
    end else if (state == ST_RUN) begin
      a_sh     <= a_sh >> DIGIT;
      b_sh     <= b_sh >> DIGIT;
      carry    <= chunk_cout;
      cnt      <= cnt + CNT_W'(1);
      diff_acc <= diff_nxt;
      if (last_chunk) begin
        io.Diff     <= diff_nxt;
        io.bout     <= ~chunk_cout;
        io.overflow <= (a_msb != b_msb) && (diff_nxt[SIZE-1] != a_msb);
        io.zero     <= (diff_nxt == '0);
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.SIZE(8))  if8  ();
  serial_subtractor_if #(.SIZE(16)) if16 ();

  serial_subtractor #(.SIZE(8), .DIGIT(1)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .io  (if8.slave)
  );

  serial_subtractor #(.SIZE(16), .DIGIT(4)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .io  (if16.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one 8-bit request, then wait (bounded) for done.
  // edges counts clock edges starting with the capture edge as 1.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      output int edges, output int bcnt);
    if8.A = a; if8.B = b; if8.bin = bi; if8.start = 1'b1;
    step();
    if8.start = 1'b0;
    edges = 1;
    bcnt  = 0;
    for (int i = 0; i < 40 && if8.done !== 1'b1; i++) begin
      if (if8.busy === 1'b1) bcnt++;
      step();
      edges++;
    end
    chk("done8_seen", {31'd0, if8.done}, 32'd1);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic bi,
                       output int edges, output int bcnt);
    if16.A = a; if16.B = b; if16.bin = bi; if16.start = 1'b1;
    step();
    if16.start = 1'b0;
    edges = 1;
    bcnt  = 0;
    for (int i = 0; i < 40 && if16.done !== 1'b1; i++) begin
      if (if16.busy === 1'b1) bcnt++;
      step();
      edges++;
    end
    chk("done16_seen", {31'd0, if16.done}, 32'd1);
  endtask

  initial begin
    int          e, bc, dcnt;
    logic [15:0] ra, rb;
    logic        rbi;
    logic [16:0] full;
    int          sres;
    logic        exp_ovf;

    if8.start = 1'b0;  if8.A = '0;  if8.B = '0;  if8.bin = 1'b0;
    if16.start = 1'b0; if16.A = '0; if16.B = '0; if16.bin = 1'b0;

    // Reset state
    rst = 1'b1;
    step(); step();
    chk("rst_busy", {31'd0, if8.busy}, 32'd0);
    chk("rst_done", {31'd0, if8.done}, 32'd0);
    chk("rst_diff", {24'd0, if8.Diff}, 32'h00);
    chk("rst_flags", {29'd0, if8.bout, if8.overflow, if8.zero}, 32'd0);
    chk("rst_diff16", {16'd0, if16.Diff}, 32'h0000);
    rst = 1'b0;
    step();

    // 5 - 3
    run8(8'h05, 8'h03, 1'b0, e, bc);
    chk("t1_edges", e, 9);
    chk("t1_busy_cycles", bc, 8);
    chk("t1_diff", {24'd0, if8.Diff}, 32'h02);
    chk("t1_bout", {31'd0, if8.bout}, 32'd0);
    chk("t1_ovf", {31'd0, if8.overflow}, 32'd0);
    chk("t1_zero", {31'd0, if8.zero}, 32'd0);
    step();
    chk("t1_done_one_cycle", {31'd0, if8.done}, 32'd0);
    chk("t1_diff_hold", {24'd0, if8.Diff}, 32'h02);
    step();

    // 3 - 5 then back-to-back 0x80 - 1
    run8(8'h03, 8'h05, 1'b0, e, bc);
    chk("t2_diff", {24'd0, if8.Diff}, 32'hFE);
    chk("t2_bout", {31'd0, if8.bout}, 32'd1);
    chk("t2_ovf", {31'd0, if8.overflow}, 32'd0);
    run8(8'h80, 8'h01, 1'b0, e, bc);
    chk("t3_edges_b2b", e, 9);
    chk("t3_diff", {24'd0, if8.Diff}, 32'h7F);
    chk("t3_bout", {31'd0, if8.bout}, 32'd0);
    chk("t3_ovf", {31'd0, if8.overflow}, 32'd1);

    // Borrow-in cases
    run8(8'h2A, 8'h29, 1'b1, e, bc);
    chk("t4_diff", {24'd0, if8.Diff}, 32'h00);
    chk("t4_zero", {31'd0, if8.zero}, 32'd1);
    chk("t4_bout", {31'd0, if8.bout}, 32'd0);
    run8(8'h00, 8'h00, 1'b1, e, bc);
    chk("t5_diff", {24'd0, if8.Diff}, 32'hFF);
    chk("t5_bout", {31'd0, if8.bout}, 32'd1);
    chk("t5_ovf", {31'd0, if8.overflow}, 32'd0);
    chk("t5_zero", {31'd0, if8.zero}, 32'd0);
    step();

    // Reset in the 4th RUN cycle aborts without done
    if8.A = 8'h05; if8.B = 8'h03; if8.bin = 1'b0; if8.start = 1'b1;
    step();
    if8.start = 1'b0;
    step(); step(); step();
    chk("t6_busy_before_rst", {31'd0, if8.busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy_after_rst", {31'd0, if8.busy}, 32'd0);
    chk("t6_diff_after_rst", {24'd0, if8.Diff}, 32'h00);
    chk("t6_flags_after_rst", {29'd0, if8.bout, if8.overflow, if8.zero}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (if8.done === 1'b1) dcnt++;
      step();
    end
    chk("t6_no_done", dcnt, 0);
    run8(8'h44, 8'h11, 1'b0, e, bc);
    chk("t6_post_rst_diff", {24'd0, if8.Diff}, 32'h33);
    chk("t6_post_rst_edges", e, 9);
    step();

    // Start during busy is ignored
    if8.A = 8'h10; if8.B = 8'h01; if8.bin = 1'b0; if8.start = 1'b1;
    step();
    if8.start = 1'b0;
    step(); step();
    if8.A = 8'h55; if8.B = 8'h11; if8.start = 1'b1;
    step();
    if8.start = 1'b0;
    for (int i = 0; i < 40 && if8.done !== 1'b1; i++) step();
    chk("t7_done_seen", {31'd0, if8.done}, 32'd1);
    chk("t7_diff_first_op", {24'd0, if8.Diff}, 32'h0F);
    // Start held in the DONE cycle is accepted
    run8(8'h20, 8'h08, 1'b0, e, bc);
    chk("t7_b2b_edges", e, 9);
    chk("t7_b2b_diff", {24'd0, if8.Diff}, 32'h18);
    step();
    chk("t7_idle_after", {30'd0, if8.busy, if8.done}, 32'd0);

    // 16-bit, 4 bits per clock
    run16(16'h1000, 16'h0001, 1'b0, e, bc);
    chk("t8_busy_cycles", bc, 4);
    chk("t8_edges", e, 5);
    chk("t8_diff", {16'd0, if16.Diff}, 32'h0FFF);
    chk("t8_bout", {31'd0, if16.bout}, 32'd0);
    chk("t8_ovf", {31'd0, if16.overflow}, 32'd0);
    step();

    // Random operations against an arithmetic reference
    for (int n = 0; n < 1000; n++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rbi = 1'($urandom_range(0, 1));
      if (n % 10 == 0) rb = ra;
      full    = {1'b0, ra} - {1'b0, rb} - {16'd0, rbi};
      sres    = int'($signed(ra)) - int'($signed(rb)) - int'(rbi);
      exp_ovf = (sres > 32767) || (sres < -32768);
      run16(ra, rb, rbi, e, bc);
      chk("rnd_diff", {16'd0, if16.Diff}, {16'd0, full[15:0]});
      chk("rnd_bout", {31'd0, if16.bout}, {31'd0, full[16]});
      chk("rnd_ovf", {31'd0, if16.overflow}, {31'd0, exp_ovf});
      chk("rnd_zero", {31'd0, if16.zero}, {31'd0, full[15:0] == 16'd0});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
